regfile_wb_scheduler: RTL and testbench



---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 35 +++
 rtl/regfile_wb_scheduler.sv | 158 +++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback scheduler.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;
    localparam int NUM_REQ  = 3;

    localparam int REQ_MDU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_ALU = 2;

    typedef logic [NUM_REQ-1:0] req_vec_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write bitmap: decode claims set a bit, granted writes clear it.
module regfile_scoreboard #(
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            claim_valid,
    input  logic [ADDR_W-1:0]               claim_reg,
    input  logic                            clr1_valid,
    input  logic [ADDR_W-1:0]               clr1_reg,
    input  logic                            clr2_valid,
    input  logic [ADDR_W-1:0]               clr2_reg,
    output logic [regfile_pkg::NUM_REGS-1:0] pending
);

    import regfile_pkg::*;

    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (claim_valid) set_mask[claim_reg] = 1'b1;
        if (clr1_valid)  clr_mask[clr1_reg]  = 1'b1;
        if (clr2_valid)  clr_mask[clr2_reg]  = 1'b1;
    end

    // Set is applied after clear so a same-cycle claim survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~clr_mask) | set_mask;
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Packs ALU/LSU/MDU writebacks onto two register-file write ports,
// with starvation counters and a pending-write scoreboard.
module regfile_wb_scheduler #(
    parameter int DATA_W       = regfile_pkg::DATA_W,
    parameter int ADDR_W       = regfile_pkg::ADDR_W,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            alu_valid,
    input  logic [ADDR_W-1:0]               alu_reg,
    input  logic [DATA_W-1:0]               alu_data,
    output logic                            alu_ready,
    input  logic                            lsu_valid,
    input  logic [ADDR_W-1:0]               lsu_reg,
    input  logic [DATA_W-1:0]               lsu_data,
    output logic                            lsu_ready,
    input  logic                            mdu_valid,
    input  logic [ADDR_W-1:0]               mdu_reg1,
    input  logic [ADDR_W-1:0]               mdu_reg2,
    input  logic [DATA_W-1:0]               mdu_data1,
    input  logic [DATA_W-1:0]               mdu_data2,
    output logic                            mdu_ready,
    input  logic                            claim_valid,
    input  logic [ADDR_W-1:0]               claim_reg,
    output logic                            rf_reg_write,
    output logic                            rf_write_op2,
    output logic [ADDR_W-1:0]               rf_write_reg1,
    output logic [ADDR_W-1:0]               rf_write_reg2,
    output logic [DATA_W-1:0]               rf_write_data1,
    output logic [DATA_W-1:0]               rf_write_data2,
    output logic [regfile_pkg::NUM_REGS-1:0] pending
);

    import regfile_pkg::*;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    req_vec_t valid, urgent, grant;
    logic [CNT_W-1:0]  cnt   [NUM_REQ];
    logic [ADDR_W-1:0] sreg  [NUM_REQ];
    logic [DATA_W-1:0] sdata [NUM_REQ];

    logic              w1_en, w2_en;
    logic [ADDR_W-1:0] w1_reg, w2_reg;
    logic [DATA_W-1:0] w1_data, w2_data;
    logic [1:0]        used;
    logic              first;

    assign valid = {alu_valid, lsu_valid, mdu_valid} & {NUM_REQ{~rst}};

    assign sreg[REQ_MDU]  = mdu_reg1;
    assign sreg[REQ_LSU]  = lsu_reg;
    assign sreg[REQ_ALU]  = alu_reg;
    assign sdata[REQ_MDU] = mdu_data1;
    assign sdata[REQ_LSU] = lsu_data;
    assign sdata[REQ_ALU] = alu_data;

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++)
            urgent[r] = (cnt[r] == LIMIT);
    end

    // Pass 0 visits urgent requesters, pass 1 the rest; MDU, LSU, ALU within each.
    always_comb begin
        grant   = '0;
        used    = 2'd0;
        first   = 1'b1;
        w1_en   = 1'b0;
        w2_en   = 1'b0;
        w1_reg  = '0;
        w2_reg  = '0;
        w1_data = '0;
        w2_data = '0;
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (valid[r] && (urgent[r] == (p == 0))) begin
                    if (r == REQ_MDU) begin
                        if (first) begin
                            grant[r] = 1'b1;
                            used     = 2'd2;
                            w1_en    = 1'b1;
                            w1_reg   = mdu_reg1;
                            if (mdu_reg1 == mdu_reg2) begin
                                w1_data = mdu_data2;
                            end else begin
                                w1_data = mdu_data1;
                                w2_en   = 1'b1;
                                w2_reg  = mdu_reg2;
                                w2_data = mdu_data2;
                            end
                        end
                    end else if (used == 2'd0) begin
                        grant[r] = 1'b1;
                        used     = 2'd1;
                        w1_en    = 1'b1;
                        w1_reg   = sreg[r];
                        w1_data  = sdata[r];
                    end else if (used == 2'd1 && sreg[r] != w1_reg) begin
                        grant[r] = 1'b1;
                        used     = 2'd2;
                        w2_en    = 1'b1;
                        w2_reg   = sreg[r];
                        w2_data  = sdata[r];
                    end
                    first = 1'b0;
                end
            end
        end
    end

    assign mdu_ready = grant[REQ_MDU];
    assign lsu_ready = grant[REQ_LSU];
    assign alu_ready = grant[REQ_ALU];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REQ; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!valid[r] || grant[r]) cnt[r] <= '0;
                else if (cnt[r] != LIMIT)  cnt[r] <= cnt[r] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_reg_write   <= 1'b0;
            rf_write_op2   <= 1'b0;
            rf_write_reg1  <= '0;
            rf_write_reg2  <= '0;
            rf_write_data1 <= '0;
            rf_write_data2 <= '0;
        end else begin
            rf_reg_write   <= w1_en;
            rf_write_op2   <= w2_en;
            rf_write_reg1  <= w1_reg;
            rf_write_reg2  <= w2_reg;
            rf_write_data1 <= w1_data;
            rf_write_data2 <= w2_data;
        end
    end

    regfile_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .claim_valid(claim_valid),
        .claim_reg  (claim_reg),
        .clr1_valid (w1_en),
        .clr1_reg   (w1_reg),
        .clr2_valid (w2_en),
        .clr2_reg   (w2_reg),
        .pending    (pending)
    );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with a register-file shadow.
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid, mdu_valid;
    logic [3:0]  alu_reg, lsu_reg, mdu_reg1, mdu_reg2;
    logic [15:0] alu_data, lsu_data, mdu_data1, mdu_data2;
    logic        alu_ready, lsu_ready, mdu_ready;
    logic        claim_valid;
    logic [3:0]  claim_reg;
    logic        rf_reg_write, rf_write_op2;
    logic [3:0]  rf_write_reg1, rf_write_reg2;
    logic [15:0] rf_write_data1, rf_write_data2;
    logic [15:0] pending;

    logic [15:0] rf_model [16] = '{default: 16'h0};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_reg       (alu_reg),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .lsu_valid     (lsu_valid),
        .lsu_reg       (lsu_reg),
        .lsu_data      (lsu_data),
        .lsu_ready     (lsu_ready),
        .mdu_valid     (mdu_valid),
        .mdu_reg1      (mdu_reg1),
        .mdu_reg2      (mdu_reg2),
        .mdu_data1     (mdu_data1),
        .mdu_data2     (mdu_data2),
        .mdu_ready     (mdu_ready),
        .claim_valid   (claim_valid),
        .claim_reg     (claim_reg),
        .rf_reg_write  (rf_reg_write),
        .rf_write_op2  (rf_write_op2),
        .rf_write_reg1 (rf_write_reg1),
        .rf_write_reg2 (rf_write_reg2),
        .rf_write_data1(rf_write_data1),
        .rf_write_data2(rf_write_data2),
        .pending       (pending)
    );

    // Register file commits whatever the scheduler presents.
    always @(posedge clk) begin
        if (rf_reg_write) rf_model[rf_write_reg1] <= rf_write_data1;
        if (rf_write_op2) rf_model[rf_write_reg2] <= rf_write_data2;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] rdy();
        return {alu_ready, lsu_ready, mdu_ready};
    endfunction

    initial begin
        rst = 1'b1;
        mdu_valid = 1'b1; mdu_reg1 = 4'd4; mdu_reg2 = 4'd5;
        mdu_data1 = 16'h1111; mdu_data2 = 16'h2222;
        alu_valid = 1'b1; alu_reg = 4'd2; alu_data = 16'hAAAA;
        lsu_valid = 1'b1; lsu_reg = 4'd3; lsu_data = 16'h5555;
        claim_valid = 1'b0; claim_reg = 4'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", rdy(), 3'b000);
        check("rst_we", {rf_reg_write, rf_write_op2}, 2'b00);
        check("rst_pending", pending, 16'h0);
        check("rst_ports", {rf_write_reg1, rf_write_reg2,
                            rf_write_data1, rf_write_data2}, 40'h0);

        rst = 1'b0;
        #1 check("mdu_first_ready", rdy(), 3'b001);
        @(posedge clk); #1;
        check("mdu_we", {rf_reg_write, rf_write_op2}, 2'b11);
        check("mdu_regs", {rf_write_reg1, rf_write_reg2}, 8'h45);
        check("mdu_data", {rf_write_data1, rf_write_data2}, 32'h11112222);

        @(negedge clk);
        mdu_valid = 1'b0;
        #1 check("pair_ready", rdy(), 3'b110);
        @(posedge clk); #1;
        check("pair_port1", {rf_reg_write, rf_write_reg1, rf_write_data1},
              {1'b1, 4'h3, 16'h5555});
        check("pair_port2", {rf_write_op2, rf_write_reg2, rf_write_data2},
              {1'b1, 4'h2, 16'hAAAA});

        @(negedge clk);
        alu_reg = 4'd6; alu_data = 16'hA6A6;
        lsu_reg = 4'd6; lsu_data = 16'h6B6B;
        #1 check("coll_ready", rdy(), 3'b010);
        @(posedge clk); #1;
        check("coll_lsu_write", {rf_reg_write, rf_write_op2, rf_write_reg1,
              rf_write_data1}, {1'b1, 1'b0, 4'h6, 16'h6B6B});
        @(negedge clk);
        lsu_valid = 1'b0;
        #1 check("coll_alu_ready", rdy(), 3'b100);
        @(posedge clk); #1;
        check("coll_alu_write", {rf_reg_write, rf_write_op2, rf_write_reg1,
              rf_write_data1}, {1'b1, 1'b0, 4'h6, 16'hA6A6});
        @(negedge clk);
        alu_valid = 1'b0;
        #1 check("idle_ready", rdy(), 3'b000);
        @(posedge clk); #1;
        check("idle_we", {rf_reg_write, rf_write_op2}, 2'b00);
        check("r6_final", rf_model[6], 16'hA6A6);

        @(negedge clk);
        mdu_valid = 1'b1; mdu_reg1 = 4'd10; mdu_reg2 = 4'd11;
        mdu_data1 = 16'h1010; mdu_data2 = 16'h1111;
        alu_valid = 1'b1; alu_reg = 4'd1; alu_data = 16'h0101;
        for (int i = 0; i < 10; i++) begin
            #1 check($sformatf("starve_ready_%0d", i), rdy(),
                     (i == 3) ? 3'b100 : 3'b001);
            @(posedge clk); #1;
            if (i == 3)
                check("starve_alu_write", {rf_reg_write, rf_write_op2,
                      rf_write_reg1, rf_write_data1},
                      {1'b1, 1'b0, 4'h1, 16'h0101});
            @(negedge clk);
            if (i == 3) alu_valid = 1'b0;
        end
        mdu_valid = 1'b0;

        claim_valid = 1'b1; claim_reg = 4'd7;
        @(posedge clk); #1;
        check("claim7", pending, 16'h0080);
        @(negedge clk);
        claim_valid = 1'b0;
        lsu_valid = 1'b1; lsu_reg = 4'd7; lsu_data = 16'h7777;
        #1 check("lsu7_ready", rdy(), 3'b010);
        @(posedge clk); #1;
        check("clear7", pending, 16'h0000);
        @(negedge clk);
        lsu_valid = 1'b0;
        claim_valid = 1'b1;
        @(posedge clk); #1;
        check("reclaim7", pending, 16'h0080);
        @(negedge clk);
        lsu_valid = 1'b1;
        @(posedge clk); #1;
        check("claim_wins", pending, 16'h0080);
        @(negedge clk);
        claim_reg = 4'd8; lsu_reg = 4'd3;
        @(posedge clk); #1;
        check("nonpending_write", pending, 16'h0180);
        @(negedge clk);
        claim_valid = 1'b0; lsu_valid = 1'b0;

        mdu_valid = 1'b1; mdu_reg1 = 4'd9; mdu_reg2 = 4'd9;
        mdu_data1 = 16'h0001; mdu_data2 = 16'h0002;
        #1 check("mdu_same_ready", rdy(), 3'b001);
        @(posedge clk); #1;
        check("mdu_same_write", {rf_reg_write, rf_write_op2, rf_write_reg1,
              rf_write_data1}, {1'b1, 1'b0, 4'h9, 16'h0002});
        @(negedge clk);
        mdu_valid = 1'b0;
        @(posedge clk); #1;
        check("r9_final", rf_model[9], 16'h0002);

        @(negedge clk);
        alu_valid = 1'b1; alu_reg = 4'd12; alu_data = 16'hC0C0;
        #1 check("pre_rst_ready", rdy(), 3'b100);
        @(posedge clk); #1;
        check("pre_rst_we", rf_reg_write, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_outputs", {rf_reg_write, rf_write_op2,
              rf_write_reg1, rf_write_data1, pending}, 64'h0);
        check("async_rst_ready", rdy(), 3'b000);
        @(negedge clk);
        alu_valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_we", {rf_reg_write, rf_write_op2}, 2'b00);
        check("r12_not_written", rf_model[12], 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
